ir_nec_tx: RTL and testbench

IR_NEC_TX -- requirements
Module: ir_nec_tx

---
 rtl/ir_nec_tx.sv | 155 +++++++++++++++
 tb/tb_ir_nec_tx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: sends lead burst, 32-bit payload {~cmd, cmd, ~addr, addr} LSB first, stop burst.
// Define IR_NEC_TX_CARRIER_EN to modulate marks with the carrier; otherwise ir_out is the bare envelope.
module ir_nec_tx #(
   parameter int UNIT_CYC     = 6750,
   parameter int CARRIER_DIV  = 316,
   parameter int CARRIER_HIGH = 105
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   input  logic [7:0] addr,
   input  logic [7:0] cmd,
   output logic       busy,
   output logic       done,
   output logic       ir_out
);

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK
   } state_t;

   // Longest state is the 16-unit lead mark, so the counter never has to wrap.
   localparam int CNT_W = (UNIT_CYC * 16 > 1) ? $clog2(UNIT_CYC * 16) : 1;
   localparam logic [CNT_W-1:0] LAST_16U = CNT_W'(UNIT_CYC * 16 - 1);
   localparam logic [CNT_W-1:0] LAST_8U  = CNT_W'(UNIT_CYC * 8 - 1);
   localparam logic [CNT_W-1:0] LAST_3U  = CNT_W'(UNIT_CYC * 3 - 1);
   localparam logic [CNT_W-1:0] LAST_1U  = CNT_W'(UNIT_CYC - 1);

   if (CARRIER_HIGH < 1 || CARRIER_HIGH >= CARRIER_DIV || UNIT_CYC < 1) begin : g_bad_params
      $error("ir_nec_tx: need UNIT_CYC >= 1 and 1 <= CARRIER_HIGH < CARRIER_DIV");
   end

   state_t           state_q, state_d;
   logic [CNT_W-1:0] unit_cnt_q, unit_cnt_d;
   logic [4:0]       bit_cnt_q, bit_cnt_d;
   logic [31:0]      shift_q, shift_d;
   logic             done_q, done_d;
   logic             ir_q, ir_d;
   logic [CNT_W-1:0] last_cnt;
   logic             unit_last;

   function automatic logic is_mark(input state_t s);
      return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
   endfunction

   always_comb begin
      last_cnt = LAST_1U;
      case (state_q)
         LEAD_MARK:  last_cnt = LAST_16U;
         LEAD_SPACE: last_cnt = LAST_8U;
         BIT_SPACE:  last_cnt = shift_q[0] ? LAST_3U : LAST_1U;
         default:    last_cnt = LAST_1U;
      endcase
      unit_last = (unit_cnt_q == last_cnt);
   end

   always_comb begin
      state_d    = state_q;
      unit_cnt_d = unit_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = LEAD_MARK;
               shift_d   = {~cmd, cmd, ~addr, addr};
               bit_cnt_d = '0;
            end
         end
         LEAD_MARK:  if (unit_last) state_d = LEAD_SPACE;
         LEAD_SPACE: if (unit_last) state_d = BIT_MARK;
         BIT_MARK:   if (unit_last) state_d = BIT_SPACE;
         BIT_SPACE: begin
            if (unit_last) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 5'd1;
               state_d   = (bit_cnt_q == 5'd31) ? STOP_MARK : BIT_MARK;
            end
         end
         STOP_MARK: begin
            if (unit_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Every state change restarts the unit count; IDLE leaves it untouched.
      if (state_d != state_q) begin
         unit_cnt_d = '0;
      end else if (state_q != IDLE) begin
         unit_cnt_d = unit_cnt_q + CNT_W'(1);
      end
   end

`ifdef IR_NEC_TX_CARRIER_EN
   localparam int CAR_W = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
   localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CARRIER_DIV - 1);

   logic [CAR_W-1:0] car_q, car_d;

   // Carrier phase restarts on every mark entry so each burst opens with the high phase.
   always_comb begin
      car_d = car_q;
      ir_d  = 1'b0;
      if (is_mark(state_d) && (state_d != state_q)) begin
         car_d = '0;
      end else if (is_mark(state_q)) begin
         car_d = (car_q == CAR_LAST) ? '0 : car_q + CAR_W'(1);
      end
      ir_d = is_mark(state_d) && (int'(car_d) < CARRIER_HIGH);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         car_q <= '0;
      end else begin
         car_q <= car_d;
      end
   end
`else
   always_comb begin
      ir_d = is_mark(state_d);
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         unit_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         done_q     <= 1'b0;
         ir_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         unit_cnt_q <= unit_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         done_q     <= done_d;
         ir_q       <= ir_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign ir_out = ir_q;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: a frame-waveform model checked every cycle, plus a monitor that decodes
// the emitted frame (length, lead burst, payload) against hand-computed values.
module tb_ir_nec_tx;

   localparam int U     = 4;
   localparam int DIV   = 3;
   localparam int HI    = 1;
   localparam int FRAME = 121 * U;

`ifdef IR_NEC_TX_CARRIER_EN
   localparam logic [5:0] HEAD_EXP       = 6'b001001;
   localparam int         FIRST_HIGH_EXP = 1;
`else
   localparam logic [5:0] HEAD_EXP       = 6'b111111;
   localparam int         FIRST_HIGH_EXP = 16 * U;
`endif

   logic       clk;
   logic       rstn;
   logic       start;
   logic [7:0] addr;
   logic [7:0] cmd;
   logic       busy;
   logic       done;
   logic       ir_out;

   int nVec = 0;
   int nMis = 0;

   ir_nec_tx #(
      .UNIT_CYC(U),
      .CARRIER_DIV(DIV),
      .CARRIER_HIGH(HI)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .start(start),
      .addr(addr),
      .cmd(cmd),
      .busy(busy),
      .done(done),
      .ir_out(ir_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: the frame is a list of mark/space segments whose lengths follow the NEC rules.
   bit mWave[FRAME];
   int wp;
   int mRem = 0;
   int mIdx = 0;
   bit mDone = 0;

   task automatic addSeg(input bit isMark, input int units);
      for (int k = 0; k < units * U; k++) begin
         if (wp < FRAME) begin
`ifdef IR_NEC_TX_CARRIER_EN
            mWave[wp] = isMark && ((k % DIV) < HI);
`else
            mWave[wp] = isMark;
`endif
         end
         wp++;
      end
   endtask

   task automatic buildWave(input logic [7:0] a, input logic [7:0] c);
      logic [31:0] payload;
      payload = {~c, c, ~a, a};
      wp = 0;
      addSeg(1'b1, 16);
      addSeg(1'b0, 8);
      for (int i = 0; i < 32; i++) begin
         addSeg(1'b1, 1);
         addSeg(1'b0, payload[i] ? 3 : 1);
      end
      addSeg(1'b1, 1);
   endtask

   // Model advances one cycle per clock edge; a new frame is taken only when the model is idle.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mRem  = 0;
         mDone = 1'b0;
      end else if (mRem == 0) begin
         mDone = 1'b0;
         if (start) begin
            buildWave(addr, cmd);
            mRem = FRAME;
            mIdx = 0;
         end
      end else begin
         mRem--;
         mIdx++;
         mDone = (mRem == 0);
      end
   end

   always @(negedge clk) begin
      if (rstn) begin
         checkOutput("busy", 32'(busy), 32'(mRem > 0));
         checkOutput("done", 32'(done), 32'(mDone));
         checkOutput("ir_out", 32'(ir_out), 32'((mRem > 0) ? mWave[mIdx] : 1'b0));
      end
   end

   // Monitor: decodes each completed frame from ir_out space lengths.
   bit          inFrame = 0;
   int          fLen, lowRun, highRun, nSpace, leadSpace, firstHigh;
   int          idleRun = 0;
   logic [31:0] fWord;
   logic [5:0]  fHead;
   int          lastLen = 0, lastLead = 0, lastGap = 0, lastFirstHigh = 0;
   int          frames = 0, doneCnt = 0;
   logic [31:0] lastWord = '0;
   logic [5:0]  lastHead = '0;

   always @(negedge clk) begin
      if (!rstn) begin
         inFrame = 1'b0;
         idleRun = 0;
      end else begin
         if (done) doneCnt++;
         if (busy) begin
            if (!inFrame) begin
               inFrame   = 1'b1;
               fLen      = 0;
               lowRun    = 0;
               highRun   = 0;
               nSpace    = 0;
               leadSpace = 0;
               firstHigh = 0;
               fWord     = '0;
               fHead     = '0;
               lastGap   = idleRun;
            end
            if (fLen < 6) fHead[fLen] = ir_out;
            fLen++;
            if (!ir_out) begin
               if (firstHigh == 0 && highRun > 0) firstHigh = highRun;
               lowRun++;
            end else begin
               highRun++;
               if (lowRun >= 3) begin
                  if (nSpace == 0) leadSpace = lowRun;
                  else if (nSpace <= 32) fWord[nSpace-1] = (lowRun >= 3 * U);
                  nSpace++;
               end
               lowRun = 0;
            end
            idleRun = 0;
         end else begin
            if (inFrame) begin
               inFrame       = 1'b0;
               lastLen       = fLen;
               lastWord      = fWord;
               lastHead      = fHead;
               lastLead      = leadSpace;
               lastFirstHigh = firstHigh;
               frames++;
            end
            idleRun++;
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] c);
      @(posedge clk);
      #1;
      addr  = a;
      cmd   = c;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int bound, input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!done && n < bound);
      checkOutput(tag, 32'(done), 32'd1);
      @(negedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int f0, d0, n;
      rstn  = 1'b1;
      start = 1'b0;
      addr  = '0;
      cmd   = '0;
      #1 rstn = 1'b0;
      #3;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_ir", 32'(ir_out), 32'd0);
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (3) @(posedge clk);

      // All-zero payload: frame timing and envelope shape.
      f0 = frames;
      d0 = doneCnt;
      applyStimulus(8'h00, 8'h00);
      waitDone(600, "zero_done_timeout");
      checkOutput("zero_len", 32'(lastLen), 32'd484);
      checkOutput("zero_frames", 32'(frames - f0), 32'd1);
      checkOutput("zero_dones", 32'(doneCnt - d0), 32'd1);
      checkOutput("zero_word", lastWord, 32'hFF00FF00);
      checkOutput("zero_lead_space", 32'(lastLead), 32'd32);
      checkOutput("zero_head", 32'(lastHead), 32'(HEAD_EXP));
      checkOutput("zero_first_high", 32'(lastFirstHigh), 32'(FIRST_HIGH_EXP));

      // Mixed payload.
      repeat (5) @(posedge clk);
      applyStimulus(8'hA5, 8'h3C);
      waitDone(600, "a5_done_timeout");
      checkOutput("a5_len", 32'(lastLen), 32'd484);
      checkOutput("a5_word", lastWord, 32'hC33C5AA5);

      // Starts during a frame are ignored, and the latched payload stays put.
      repeat (5) @(posedge clk);
      f0 = frames;
      applyStimulus(8'h12, 8'h34);
      for (int i = 0; i < 10; i++) begin
         repeat (20) @(posedge clk);
         #1;
         addr  = 8'h40 + 8'(i);
         cmd   = 8'h80 + 8'(i);
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      waitDone(600, "ignore_done_timeout");
      checkOutput("ignore_word", lastWord, 32'hCB34ED12);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("ignore_frames", 32'(frames - f0), 32'd1);

      // Start held high: back-to-back frames, accepted on the done cycle.
      f0 = frames;
      d0 = doneCnt;
      @(posedge clk);
      #1;
      addr  = 8'h5A;
      cmd   = 8'h0F;
      start = 1'b1;
      waitDone(600, "held1_done_timeout");
      checkOutput("held1_len", 32'(lastLen), 32'd484);
      waitDone(600, "held2_done_timeout");
      start = 1'b0;
      checkOutput("held2_len", 32'(lastLen), 32'd484);
      checkOutput("held_gap", 32'(lastGap), 32'd1);
      checkOutput("held_word", lastWord, 32'hF00FA55A);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("held_frames", 32'(frames - f0), 32'd2);
      checkOutput("held_dones", 32'(doneCnt - d0), 32'd2);

      // Reset mid-frame aborts without done; a later start gives a full frame.
      f0 = frames;
      d0 = doneCnt;
      applyStimulus(8'h00, 8'h00);
      repeat (200) @(posedge clk);
      #1;
      n = 0;
      while (!ir_out && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("pre_reset_ir", 32'(ir_out), 32'd1);
      #1 rstn = 1'b0;
      #1;
      checkOutput("async_busy", 32'(busy), 32'd0);
      checkOutput("async_ir", 32'(ir_out), 32'd0);
      checkOutput("async_done", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (600) @(posedge clk);
      #1;
      checkOutput("abort_no_done", 32'(doneCnt - d0), 32'd0);
      checkOutput("abort_idle", 32'(busy), 32'd0);
      applyStimulus(8'h5A, 8'hC3);
      waitDone(600, "after_reset_timeout");
      checkOutput("after_reset_len", 32'(lastLen), 32'd484);
      checkOutput("after_reset_word", lastWord, 32'h3CC3A55A);
      checkOutput("after_reset_frames", 32'(frames - f0), 32'd1);

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
